// File: rtl/fb_rect_fill.sv
// fb_rect_fill: clips rectangle commands to the screen and fills them one framebuffer write per clock; define FB_VSYNC_WAIT_EN to start fills on the v_sync falling edge
module fb_rect_fill #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = RES_X * RES_Y,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int X_W        = $clog2(RES_X + 1),
  parameter int Y_W        = $clog2(RES_Y + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FB_VSYNC_WAIT_EN
  input  logic                  v_sync,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_W-1:0]        cmd_x0,
  input  logic [Y_W-1:0]        cmd_y0,
  input  logic [X_W-1:0]        cmd_w,
  input  logic [Y_W-1:0]        cmd_h,
  input  logic [MEM_WIDTH-1:0]  cmd_color,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  din,
  output logic                  wen,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, SETUP, FILL, DONE, VWAIT} state_t;
  state_t state, state_nx;
  logic [X_W-1:0] x0, w, x, x_end;
  logic [Y_W-1:0] y0, h, y, y_end;
  logic [MEM_WIDTH-1:0] color;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic accept, degen, row_last, last, start;
`ifdef FB_VSYNC_WAIT_EN
  localparam state_t RUN = VWAIT;
  logic vs_q, vs_qq;
  always_ff @(posedge clk) begin
    vs_q  <= rst ? 1'b1 : v_sync;
    vs_qq <= rst ? 1'b1 : vs_q;
  end
  assign start = vs_qq && !vs_q;
`else
  localparam state_t RUN = FILL;
  assign start = 1'b1;
`endif
  assign accept   = cmd_valid && cmd_ready;
  assign x_sum    = {1'b0, x0} + {1'b0, w};
  assign y_sum    = {1'b0, y0} + {1'b0, h};
  assign degen    = w == '0 || h == '0 || x0 >= X_W'(RES_X) || y0 >= Y_W'(RES_Y);
  assign row_last = x + X_W'(1) == x_end;
  assign last     = row_last && y + Y_W'(1) == y_end;
  always_comb begin
    state_nx = state == IDLE  ? (accept ? SETUP : IDLE) :
               state == SETUP ? (degen ? DONE : RUN) :
               state == VWAIT ? (start ? FILL : VWAIT) :
               state == FILL  ? (last ? DONE : FILL) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wen       <= 1'b0;
      mem_addr  <= '0;
      din       <= '0;
    end else begin
      state     <= state_nx;
      cmd_ready <= state == IDLE && !accept;
      busy      <= state != IDLE || accept;
      done      <= state == DONE;
      wen       <= state == FILL;
      mem_addr  <= state == FILL ? row_base + ADDR_WIDTH'(x) : '0;
      din       <= state == FILL ? color : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      x0    <= cmd_x0;
      y0    <= cmd_y0;
      w     <= cmd_w;
      h     <= cmd_h;
      color <= cmd_color;
    end
    if (state == SETUP) begin
      x        <= x0;
      y        <= y0;
      x_end    <= x_sum > (X_W+1)'(RES_X) ? X_W'(RES_X) : x_sum[X_W-1:0];
      y_end    <= y_sum > (Y_W+1)'(RES_Y) ? Y_W'(RES_Y) : y_sum[Y_W-1:0];
      row_base <= ADDR_WIDTH'(y0) * ADDR_WIDTH'(RES_X);
    end
    if (state == FILL) begin
      x <= row_last ? x0 : x + X_W'(1);
      if (row_last) begin
        y        <= y + Y_W'(1);
        row_base <= row_base + ADDR_WIDTH'(RES_X);
      end
    end
  end
endmodule
